// File: rtl/title_bitmap_engine_pkg.sv
// Shared types and constants for the title bitmap engine: FSM states, colours and
// the glyph ROM image (index order [title][row][column], bit 0 = ink).
package title_pkg;

  typedef enum logic [1:0] {IDLE, REVEAL, SHOW} title_state_e;

  localparam logic [7:0] TITLE_COLOR = 8'hFF;
  localparam logic [7:0] TRANSPARENT = 8'h00;

  localparam int ROM_W      = 64;
  localparam int ROM_H      = 16;
  localparam int ROM_TITLES = 4;
  localparam int ROM_XW     = $clog2(ROM_W);
  localparam int ROM_YW     = $clog2(ROM_H);
  localparam int ROM_SW     = (ROM_TITLES > 1) ? $clog2(ROM_TITLES) : 1;

  typedef logic [ROM_TITLES-1:0][ROM_H-1:0][ROM_W-1:0] title_rom_t;

  // Glyph artwork: diagonal stripes whose phase shifts by one column per title.
  function automatic title_rom_t build_title_rom();
    title_rom_t r;
    for (int t = 0; t < ROM_TITLES; t++)
      for (int y = 0; y < ROM_H; y++)
        for (int x = 0; x < ROM_W; x++)
          r[ROM_SW'(t)][ROM_YW'(y)][ROM_XW'(x)] = ((x + y + t) % 3) != 0;
    return r;
  endfunction

  localparam title_rom_t TITLE_ROM = build_title_rom();

endpackage

// File: rtl/title_bitmap_engine_if.sv
// Pixel bus between the rectangle-position block (master) and the title renderer (slave).
interface title_bitmap_engine_if;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        drawingRequest;
  logic [7:0]  RGBout;

  modport master (output offsetX, offsetY, InsideRectangle, input drawingRequest, RGBout);
  modport slave  (input offsetX, offsetY, InsideRectangle, output drawingRequest, RGBout);
endinterface

// File: rtl/title_bitmap_engine_rom.sv
// Combinational glyph lookup: (title, row, column) -> bitmap bit.
module title_rom
  import title_pkg::*;
(
  input  logic [ROM_SW-1:0] sel_i,
  input  logic [ROM_YW-1:0] sy_i,
  input  logic [ROM_XW-1:0] sx_i,
  output logic              bit_o
);
  assign bit_o = TITLE_ROM[sel_i][sy_i][sx_i];
endmodule

// File: rtl/title_bitmap_engine.sv
// Title renderer: reveal/show FSM with a column-wipe counter and a 2-stage pixel pipeline.
// Blinking while SHOW is built only when the TITLE_BLINK_EN macro is defined.
module title_bitmap_engine
  import title_pkg::*;
#(
  parameter int         WIDTH         = ROM_W,
  parameter int         HEIGHT        = ROM_H,
  parameter int         NUM_TITLES    = ROM_TITLES,
  parameter int         SCALE_LOG2    = 0,
  parameter logic [7:0] COLOR         = TITLE_COLOR,
  parameter int         REVEAL_FRAMES = 2,
  parameter int         BLINK_FRAMES  = 30,
  localparam int        SEL_W         = (NUM_TITLES > 1) ? $clog2(NUM_TITLES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 startOfFrame,
  input  logic [SEL_W-1:0]     titleSel,
  input  logic                 revealStart,
  input  logic                 blinkOn,
  title_bitmap_engine_if.slave pix,
  output logic                 revealDone
);
  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int FRM_W = $clog2(REVEAL_FRAMES + 1);

  title_state_e     state_q;
  logic [COL_W-1:0] revealCol_q;
  logic [FRM_W-1:0] frameCnt_q;
  logic             revealDone_q;
  logic [SEL_W-1:0] activeSel_q;
  logic             first_q;
  logic             blinkVis;

  // Disable outranks a restart; a restart outranks frame counting.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q      <= IDLE;
      revealCol_q  <= '0;
      frameCnt_q   <= '0;
      revealDone_q <= 1'b0;
    end else if (revealStart) begin
      state_q      <= REVEAL;
      revealCol_q  <= '0;
      frameCnt_q   <= '0;
      revealDone_q <= 1'b0;
    end else if (state_q == REVEAL && startOfFrame) begin
      if (frameCnt_q == FRM_W'(REVEAL_FRAMES - 1)) begin
        frameCnt_q  <= '0;
        revealCol_q <= revealCol_q + COL_W'(1);
        if (revealCol_q == COL_W'(WIDTH - 1)) begin
          state_q      <= SHOW;
          revealDone_q <= 1'b1;
        end
      end else begin
        frameCnt_q <= frameCnt_q + FRM_W'(1);
      end
    end
  end

  // Title selection only changes at frame boundaries to avoid tearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      activeSel_q <= '0;
      first_q     <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if ((startOfFrame || first_q) && (32'(titleSel) < NUM_TITLES))
        activeSel_q <= titleSel;
    end
  end

`ifdef TITLE_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  logic [BLK_W-1:0] blinkCnt_q;
  logic             blinkPhase_q;

  always_ff @(posedge clk) begin
    if (reset || !enable || revealStart || !blinkOn || state_q != SHOW) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b1;
    end else if (startOfFrame) begin
      if (blinkCnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blinkCnt_q   <= '0;
        blinkPhase_q <= ~blinkPhase_q;
      end else begin
        blinkCnt_q <= blinkCnt_q + BLK_W'(1);
      end
    end
  end
  assign blinkVis = blinkPhase_q;
`else
  logic unused_blinkOn;
  assign unused_blinkOn = blinkOn;
  assign blinkVis       = 1'b1;
`endif

  logic [10:0]       sxFull, syFull;
  logic              shown, vis_d;
  logic [ROM_XW-1:0] sx_p1;
  logic [ROM_YW-1:0] sy_p1;
  logic              vld_p1;
  logic              romBit;
  logic              drawingRequest_q;
  logic [7:0]        RGBout_q;

  always_comb begin
    sxFull = pix.offsetX >> SCALE_LOG2;
    syFull = pix.offsetY >> SCALE_LOG2;
    shown  = 1'b0;
    if (state_q == SHOW)
      shown = 1'b1;
    else if (state_q == REVEAL)
      shown = 32'(sxFull) < 32'(revealCol_q);
    vis_d = pix.InsideRectangle && shown && blinkVis &&
            (32'(sxFull) < WIDTH) && (32'(syFull) < HEIGHT);
  end

  // Stage 1: source coordinates and visibility qualifier
  always_ff @(posedge clk) begin
    sx_p1 <= sxFull[ROM_XW-1:0];
    sy_p1 <= syFull[ROM_YW-1:0];
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vis_d;
  end

  title_rom u_rom (
    .sel_i (ROM_SW'(activeSel_q)),
    .sy_i  (sy_p1),
    .sx_i  (sx_p1),
    .bit_o (romBit)
  );

  // Stage 2: ROM bit resolved into request and colour
  always_ff @(posedge clk) begin
    if (reset) begin
      drawingRequest_q <= 1'b0;
      RGBout_q         <= TRANSPARENT;
    end else begin
      drawingRequest_q <= vld_p1 && !romBit;
      RGBout_q         <= (vld_p1 && !romBit) ? COLOR : TRANSPARENT;
    end
  end

  assign pix.drawingRequest = drawingRequest_q;
  assign pix.RGBout         = RGBout_q;
  assign revealDone         = revealDone_q;

endmodule

// File: tb/tb_title_bitmap_engine.sv
// Directed bench for title_bitmap_engine (NUM_TITLES=3, SCALE_LOG2=1); glyph ink at (x+y+title)%3==0.
module tb_title_bitmap_engine;
  logic       clk = 1'b0;
  logic       reset, enable, sof, revealStart, blinkOn, revealDone;
  logic [1:0] titleSel;
  int         errors = 0;
  int         checks = 0;

  title_bitmap_engine_if pix();

  title_bitmap_engine #(.NUM_TITLES(3), .SCALE_LOG2(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .startOfFrame (sof),
    .titleSel     (titleSel),
    .revealStart  (revealStart),
    .blinkOn      (blinkOn),
    .pix          (pix),
    .revealDone   (revealDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    tick();
  endtask

  task automatic chk_pix(input string tag, input int ox, input int oy, input logic ins, input logic vis);
    pix.offsetX = 11'(ox);
    pix.offsetY = 11'(oy);
    pix.InsideRectangle = ins;
    tick();
    tick();
    check({tag, "_dr"}, 32'(pix.drawingRequest), 32'(vis));
    check({tag, "_rgb"}, 32'(pix.RGBout), vis ? 32'hFF : 32'h00);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sof = 1'b0; revealStart = 1'b0; blinkOn = 1'b0;
    titleSel = 2'd0;
    pix.offsetX = 11'd0; pix.offsetY = 11'd0; pix.InsideRectangle = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rgb", 32'(pix.RGBout), 32'h00);
      check("rst_dr", 32'(pix.drawingRequest), 32'd0);
      check("rst_done", 32'(revealDone), 32'd0);
    end
    reset = 1'b0;
    tick();
    check("post_rst_rgb", 32'(pix.RGBout), 32'h00);
    check("post_rst_dr", 32'(pix.drawingRequest), 32'd0);
    check("post_rst_done", 32'(revealDone), 32'd0);

    enable = 1'b1;
    chk_pix("idle_blank", 0, 0, 1'b1, 1'b0);

    // Reveal wipe: revealCol=10 after 20 frames
    revealStart = 1'b1; tick(); revealStart = 1'b0;
    repeat (20) sof_pulse();
    chk_pix("rev_sx9_ink", 18, 0, 1'b1, 1'b1);
    chk_pix("rev_sx10_ink", 20, 4, 1'b1, 1'b0);
    chk_pix("rev_sx8_bg", 16, 0, 1'b1, 1'b0);
    repeat (107) sof_pulse();
    check("rev_done_127", 32'(revealDone), 32'd0);
    sof = 1'b1; tick(); sof = 1'b0;
    check("rev_done_128", 32'(revealDone), 32'd1);
    tick();

    // Scaling in SHOW
    chk_pix("sc_x2", 2, 4, 1'b1, 1'b1);
    chk_pix("sc_x3", 3, 5, 1'b1, 1'b1);
    chk_pix("sc_bg", 2, 0, 1'b1, 1'b0);
    chk_pix("sc_x128", 128, 4, 1'b1, 1'b0);
    chk_pix("sc_x126", 126, 0, 1'b1, 1'b1);
    chk_pix("sc_y30", 0, 30, 1'b1, 1'b1);
    chk_pix("sc_y32", 0, 32, 1'b1, 1'b0);
    chk_pix("sc_outside", 2, 4, 1'b0, 1'b0);
    pix.offsetX = 11'd2; pix.offsetY = 11'd4; pix.InsideRectangle = 1'b1;
    tick();
    check("lat_1cyc", 32'(pix.drawingRequest), 32'd0);
    tick();
    check("lat_2cyc", 32'(pix.drawingRequest), 32'd1);
    check("lat_2cyc_rgb", 32'(pix.RGBout), 32'hFF);

    // Title switch waits for startOfFrame; out-of-range index ignored
    titleSel = 2'd1;
    tick();
    chk_pix("tsel_hold", 2, 2, 1'b1, 1'b0);
    sof_pulse();
    chk_pix("tsel_new", 2, 2, 1'b1, 1'b1);
    chk_pix("tsel_new_bg", 2, 4, 1'b1, 1'b0);
    titleSel = 2'd3;
    sof_pulse();
    chk_pix("tsel_oor", 2, 2, 1'b1, 1'b1);
    titleSel = 2'd2;
    sof_pulse();
    chk_pix("tsel_2", 2, 0, 1'b1, 1'b1);
    titleSel = 2'd0;
    sof_pulse();
    chk_pix("tsel_back0", 2, 4, 1'b1, 1'b1);

`ifdef TITLE_BLINK_EN
    blinkOn = 1'b1;
    repeat (29) sof_pulse();
    chk_pix("blink_vis29", 2, 4, 1'b1, 1'b1);
    sof_pulse();
    chk_pix("blink_off30", 2, 4, 1'b1, 1'b0);
    repeat (29) sof_pulse();
    chk_pix("blink_off59", 2, 4, 1'b1, 1'b0);
    sof_pulse();
    chk_pix("blink_on60", 2, 4, 1'b1, 1'b1);
    repeat (30) sof_pulse();
    chk_pix("blink_off90", 2, 4, 1'b1, 1'b0);
    blinkOn = 1'b0;
    tick();
    chk_pix("blink_drop", 2, 4, 1'b1, 1'b1);
`else
    blinkOn = 1'b1;
    repeat (30) sof_pulse();
    chk_pix("noblink_vis", 2, 4, 1'b1, 1'b1);
    blinkOn = 1'b0;
`endif

    // Disable beats revealStart; re-enable alone stays idle
    enable = 1'b0; revealStart = 1'b1;
    tick();
    revealStart = 1'b0;
    check("gate_done", 32'(revealDone), 32'd0);
    chk_pix("gate_blank", 2, 4, 1'b1, 1'b0);
    enable = 1'b1;
    repeat (3) tick();
    chk_pix("reen_idle", 2, 4, 1'b1, 1'b0);
    check("reen_done", 32'(revealDone), 32'd0);

    // Restart coinciding with startOfFrame clears counters instead of counting
    revealStart = 1'b1; tick(); revealStart = 1'b0;
    repeat (2) sof_pulse();
    sof = 1'b1; revealStart = 1'b1;
    tick();
    sof = 1'b0; revealStart = 1'b0;
    repeat (2) sof_pulse();
    chk_pix("restart_sx0", 0, 0, 1'b1, 1'b1);
    chk_pix("restart_sx1", 2, 4, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/title_bitmap_engine.md
# title_bitmap_engine

Parametrised 1-bit title renderer for the VGA object chain (score, lives, level, game-over titles). It holds NUM_TITLES monochrome glyph bitmaps and scales the selected one by 2^SCALE_LOG2. It adds a per-frame column-wipe reveal and optional blinking, then emits an 8-bit RGB pixel and a drawing request to the priority mux. Pixel lookup is a two-stage pipeline fed by the rectangle-position block's offsets.

## Interface
- WIDTH, 64: bitmap width in source pixels (≤256).
- HEIGHT, 16: bitmap height in source pixels (≤64).
- NUM_TITLES, 4: number of selectable bitmaps (≥1).
- SCALE_LOG2, 0: integer upscale exponent (0..3).
- COLOR, 8'hFF: RGB drawn for ink pixels.
- REVEAL_FRAMES, 2: frames per revealed source column.
- BLINK_FRAMES, 30: frames per blink half-period.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  game-active gate; low forces IDLE.
- startOfFrame  in  1  one-cycle pulse per frame.
- titleSel  in  $clog2(NUM_TITLES) (min 1)  bitmap index.
- revealStart  in  1  one-cycle pulse; begins wipe.
- blinkOn  in  1  request blinking while SHOWN.
- offsetX, offsetY  in  11 each  offset from rectangle top-left.
- InsideRectangle  in  1  pixel lies in the object bracket.
- drawingRequest  out  1  pixel is opaque.
- RGBout  out  8  pixel colour; 8'h00 when transparent.
- revealDone  out  1  level, high in SHOW.

## Operation
- Ink rule: bitmap bit 0 = ink (COLOR); bit 1 = transparent (8'h00).
- Source coords: sx = offsetX >> SCALE_LOG2, sy = offsetY >> SCALE_LOG2. The pixel is transparent if sx ≥ WIDTH, sy ≥ HEIGHT, or InsideRectangle=0.
- titleSel is latched into activeSel only on startOfFrame, so there is no mid-frame tearing. It is also latched on the first cycle out of reset. Out-of-range titleSel is ignored; the previous value is held.
- FSM states: IDLE, REVEAL, SHOW.
  - IDLE: all pixels transparent. revealStart & enable → REVEAL with revealCol=0 and frameCnt=0.
  - REVEAL: on each startOfFrame, frameCnt increments. When frameCnt reaches REVEAL_FRAMES-1, frameCnt clears and revealCol increments. Pixels with sx ≥ revealCol are transparent. When revealCol reaches WIDTH → SHOW.
  - SHOW: the full bitmap is drawn and revealDone=1.
  - A revealStart in REVEAL or SHOW restarts the wipe: → REVEAL, counters cleared.
  - enable=0 in any state → IDLE on the next edge. This has priority over revealStart.
- Simultaneous startOfFrame and revealStart: the restart wins; counters are cleared, not incremented.
- Counters saturate and never wrap. revealCol is $clog2(WIDTH+1) bits.

## Timing
- Reset values: state=IDLE, revealCol=0, frameCnt=0, blinkCnt=0, blinkPhase=1 (visible), activeSel=0, RGBout=8'h00, drawingRequest=0, revealDone=0.
- Latency is 2 cycles from offsetX/offsetY/InsideRectangle to RGBout/drawingRequest.
  - Stage 1 registers sx, sy, and the in-range and visibility qualifiers.
  - Stage 2 registers the ROM bit and the colour.
- drawingRequest is registered with RGBout in the same cycle; it is never derived combinationally from RGBout.
- State changes affect pixels entering stage 1 on the cycle after the transition.
- revealDone is registered and rises on the cycle state becomes SHOW.

## Configuration
- TITLE_BLINK_EN defined:
  - In SHOW with blinkOn=1, blinkCnt counts startOfFrame pulses. At BLINK_FRAMES-1 it clears and blinkPhase toggles.
  - blinkPhase=0 forces pixels transparent.
  - blinkOn=0 or leaving SHOW resets blinkCnt=0 and blinkPhase=1.
- TITLE_BLINK_EN undefined: no blink logic is synthesised, blinkOn is ignored, and SHOW is always visible.

## Structure
- Package title_pkg holds:
  - the state enum typedef (IDLE/REVEAL/SHOW);
  - the COLOR and TRANSPARENT constants;
  - the bitmap ROM contents as a localparam array [NUM_TITLES][HEIGHT][WIDTH].
- Sub-module title_rom: a combinational lookup (activeSel, sy, sx) → bit, instantiated in stage 2.
- FSM, counters and pipeline live in the top module.

## Test plan
- Reset: assert reset 3 cycles with InsideRectangle=1 → RGBout=8'h00, drawingRequest=0, revealDone=0 throughout and one cycle after release.
- Reveal: revealStart, REVEAL_FRAMES=2, WIDTH=64 → revealDone rises after exactly 128 startOfFrame pulses. At revealCol=10, ink at sx=9 draws and ink at sx=10 is transparent.
- Scaling: SCALE_LOG2=1, in SHOW → offsetX=2,3 both map to sx=1. offsetX=128 (sx=64) is transparent. RGBout appears 2 cycles after offset presentation.
- Title switch: change titleSel mid-frame → output unchanged until the next startOfFrame, then new bitmap pixels appear. titleSel=NUM_TITLES is ignored.
- Gate priority: enable=0 in the same cycle as revealStart → state=IDLE and all pixels transparent 2 cycles later. Re-enabling without revealStart stays IDLE.
- Blink (TITLE_BLINK_EN, BLINK_FRAMES=30): blinkOn in SHOW → visible 30 frames, blank 30 frames, repeating. Drop blinkOn → visible on the next pixel.
